// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: machine word, PC increment, default reset vector and
// the {pc, instr} entry carried from fetch to decode.
package mips_pkg;
  typedef logic [31:0] word_t;

  localparam word_t PC_STEP          = 32'd4;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched {pc, instr} entries ahead of decode.
// Flush wins over push/pop in the same cycle; head is valid whenever !empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: nothing reads it while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one imem read per cycle when buffer space allows,
// and delivers {instr, pc} to decode; redirects flush everything younger.
module instr_fetch
  import mips_pkg::*;
#(
  parameter word_t RESET_PC   = DEFAULT_RESET_PC,
  parameter int    IMEM_AW    = 8,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  word_t         fetch_pc, inflight_pc;
  logic          inflight;
  logic          push, pop, flush, full, empty;
  logic [CW-1:0] count;
  logic [CW:0]   budget;
  fetch_entry_t  entry_in, head;

  // Slots already claimed (buffered + outstanding), minus the one leaving this cycle.
  assign budget   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_req = RST_N && !redirect_valid && (budget < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  assign pop   = instr_valid && instr_ready;
  assign flush = redirect_valid;
  // A response landing in a redirect cycle belongs to the old path: drop it.
  assign push  = inflight && !redirect_valid;

  assign entry_in = '{pc: inflight_pc, instr: imem_rdata};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (entry_in),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  assign instr_valid = !empty;
  assign instr       = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      assert (!(push && full))
        else $error("instr_fetch: push into full fetch FIFO");
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked each cycle
// against a queue-based transaction model; a second instance checks PC wrap from RESET_PC.
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET2 = 32'hFFFF_FFFC;

  logic        CLK = 1'b0;
  logic        RST_N, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, instr_valid;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0, instr, instr_pc;

  logic        imem_req2, instr_valid2;
  logic [7:0]  imem_addr2;
  logic [31:0] imem_rdata2 = '0, instr2, instr_pc2;

  int checks = 0;
  int failures = 0;

  logic [31:0] fq[$];
  logic [31:0] infl[$];
  logic [31:0] mpc = 32'h0;
  int          k2 = 0;

  always #5 CLK = ~CLK;

  instr_fetch dut (
    .CLK(CLK), .RST_N(RST_N), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  instr_fetch #(.RESET_PC(RESET2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .instr_ready(1'b1)
  );

  function automatic logic [31:0] lw_op(input logic [7:0] i);
    return {6'h23, i[4:0], i[4:0], 8'h00, i};
  endfunction

  // imem: one-cycle read latency, garbage when not requested
  always @(posedge CLK) begin
    imem_rdata  <= imem_req  ? lw_op(imem_addr)  : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_req2 ? lw_op(imem_addr2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input logic rst, input logic rd, input logic [31:0] rp, input logic rdy);
    logic        ev, er, ev2;
    int          pop, occ;
    logic [31:0] hp, p2, a2;
    RST_N = rst; redirect_valid = rd; redirect_pc = rp; instr_ready = rdy;
    #1;
    ev  = (fq.size() > 0);
    hp  = ev ? fq[0] : 32'h0;
    pop = (ev && rdy) ? 1 : 0;
    occ = fq.size() + infl.size() - pop;
    er  = rst && !rd && (occ < DEPTH);
    chk("req", {31'b0, imem_req}, {31'b0, er});
    if (er) chk("addr", {24'b0, imem_addr}, {24'b0, mpc[9:2]});
    chk("valid", {31'b0, instr_valid}, {31'b0, ev});
    chk("pc", instr_pc, hp);
    chk("instr", instr, ev ? lw_op(hp[9:2]) : 32'h0);

    ev2 = (k2 >= 2);
    p2  = ev2 ? RESET2 + 32'(k2 - 2) * 32'd4 : 32'h0;
    a2  = RESET2 + 32'(k2) * 32'd4;
    chk("req2", {31'b0, imem_req2}, {31'b0, rst});
    if (rst) chk("addr2", {24'b0, imem_addr2}, {24'b0, a2[9:2]});
    chk("valid2", {31'b0, instr_valid2}, {31'b0, ev2});
    chk("pc2", instr_pc2, p2);
    chk("instr2", instr2, ev2 ? lw_op(p2[9:2]) : 32'h0);

    if (!rst) begin
      fq.delete(); infl.delete(); mpc = 32'h0; k2 = 0;
    end else begin
      k2++;
      if (rd) begin
        fq.delete(); infl.delete(); mpc = {rp[31:2], 2'b00};
      end else begin
        if (pop != 0) void'(fq.pop_front());
        if (infl.size() > 0) begin fq.push_back(infl[0]); infl.delete(); end
        if (er) begin infl.push_back(mpc); mpc = mpc + 32'd4; end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    @(negedge CLK);
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);             // reset held two cycles
    repeat (8) cycle(1, 0, 0, 1);                    // first fetch latency, streaming
    repeat (6) cycle(1, 0, 0, 0);                    // decode stall
    repeat (6) cycle(1, 0, 0, 1);                    // drain in order
    repeat (4) cycle(1, 0, 0, 0);                    // fill the buffer
    cycle(1, 1, 32'h40, 0);                          // redirect while full
    repeat (6) cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h43, 1);                          // unaligned target + handshake
    repeat (6) cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h100, 1); cycle(1, 1, 32'h200, 1); // back-to-back, last wins
    repeat (5) cycle(1, 0, 0, 1);
    cycle(1, 1, 32'hFFFF_FFF4, 1);                   // wrap through zero
    repeat (6) cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);                               // reset mid-stream
    repeat (6) cycle(1, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 11) == 0,
            $urandom, $urandom_range(0, 9) < 7);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
